// File: rtl/delay_mod_ctrl.sv
// delay_mod_ctrl: glides base_delay toward the configured target and
// generates a triangle-LFO offset (mod_val) for the delay core.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   sample_en         one-cycle audio sample strobe
//   cfg_valid/ready   configuration handshake (ready only while idle)
//   cfg_delay         target base delay (0 clamps to 1)
//   cfg_depth         LFO depth in samples
//   cfg_rate          LFO phase increment per sample
//   base_delay        delay to core
//   mod_val           signed modulation offset to core
//   core_en           sample_en registered, aligned with fresh outputs
//   busy              glide in progress
//
// Optional: define DELAY_MOD_CTRL_PHASE_RST_EN so every accepted
// configuration restarts the LFO phase at 0.
module delay_mod_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int RATE_W     = 16,
  parameter int STEP       = 1,
  parameter int INIT_DELAY = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_delay,
  input  logic [ADDR_W-1:0] cfg_depth,
  input  logic [RATE_W-1:0] cfg_rate,
  output logic [ADDR_W-1:0] base_delay,
  output logic [15:0]       mod_val,
  output logic              core_en,
  output logic              busy
);

  localparam int P_W = 16 + ADDR_W + 1;

  typedef enum logic {
    IDLE,
    GLIDE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] depth_q, depth_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] phase_q, phase_d;
  logic [15:0]       mod_q, mod_d;
  logic              en_q;

  logic              accept;
  logic [ADDR_W-1:0] cfg_tgt;
  logic [14:0]       tri_w;
  logic signed [15:0]    bip;
  logic signed [ADDR_W:0] depth_s;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] prod_sh;
  logic              up;
  logic [ADDR_W-1:0] diff;
  logic              near;

  assign accept  = cfg_valid && (state_q == IDLE);
  assign cfg_tgt = (cfg_delay == '0) ? ADDR_W'(1) : cfg_delay;

  // Triangle from phase, centred around zero, scaled by depth / 2^14.
  assign tri_w   = phase_q[15] ? ~phase_q[14:0] : phase_q[14:0];
  assign bip     = $signed({1'b0, tri_w}) - 16'sd16384;
  assign depth_s = $signed({1'b0, depth_q});
  assign prod    = P_W'(bip) * P_W'(depth_s);
  assign prod_sh = prod >>> 14;

  // Glide distance; operands ordered so the subtraction never wraps.
  assign up   = target_q > base_q;
  assign diff = up ? (target_q - base_q) : (base_q - target_q);
  assign near = diff <= ADDR_W'(STEP);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    target_d = target_q;
    depth_d  = depth_q;
    rate_d   = rate_q;
    phase_d  = phase_q;
    mod_d    = mod_q;

    if (sample_en) begin
      mod_d   = prod_sh[15:0];
      phase_d = phase_q + rate_q;
      if (state_q == GLIDE) begin
        if (near) begin
          base_d  = target_q;
          state_d = IDLE;
        end else if (up) begin
          base_d = base_q + ADDR_W'(STEP);
        end else begin
          base_d = base_q - ADDR_W'(STEP);
        end
      end
    end

    // Accept only happens in IDLE, so it never races a glide step.
    if (accept) begin
      depth_d  = cfg_depth;
      rate_d   = cfg_rate;
      target_d = cfg_tgt;
      state_d  = (cfg_tgt != base_q) ? GLIDE : IDLE;
`ifdef DELAY_MOD_CTRL_PHASE_RST_EN
      phase_d  = '0;
`else
      phase_d  = phase_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= ADDR_W'(INIT_DELAY);
      target_q <= ADDR_W'(INIT_DELAY);
      depth_q  <= '0;
      rate_q   <= '0;
      phase_q  <= '0;
      mod_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      target_q <= target_d;
      depth_q  <= depth_d;
      rate_q   <= rate_d;
      phase_q  <= phase_d;
      mod_q    <= mod_d;
      en_q     <= sample_en;
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q == GLIDE);
  assign base_delay = base_q;
  assign mod_val    = mod_q;
  assign core_en    = en_q;

endmodule

// File: doc/delay_mod_ctrl.md
Name: delay_mod_ctrl

Overview:
- Control-plane sequencer that drives the delay core's `base_delay`, `mod_val` and `en` inputs.
- Accepts delay/modulation configuration over a valid/ready handshake.
- Glides `base_delay` toward each new target at a bounded slew per sample, avoiding zipper clicks.
- Generates a triangle-LFO modulation offset scaled by a depth in samples; sits between the register interface and the delay core.

Parameters:
- ADDR_W, 12, delay address width; must match the delay core.
- RATE_W, 16, LFO phase accumulator width (fixed at 16; the triangle math below assumes 16).
- STEP, 1, maximum `base_delay` change per sample during a glide.
- INIT_DELAY, 1024, `base_delay` value after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- sample_en  in  1  one-cycle audio sample strobe.
- cfg_valid  in  1  configuration request valid.
- cfg_ready  out  1  configuration can be accepted.
- cfg_delay  in  ADDR_W  target base delay in samples.
- cfg_depth  in  ADDR_W  LFO depth in samples (unsigned).
- cfg_rate  in  RATE_W  LFO phase increment per sample.
- base_delay  out  ADDR_W  to delay core.
- mod_val  out  16  signed modulation offset to delay core.
- core_en  out  1  delay core enable; sample_en delayed one cycle.
- busy  out  1  glide in progress.

Behaviour:
- Reset, synchronous with rst_n=0 at a clk edge:
  - base_delay=INIT_DELAY, mod_val=0, core_en=0, cfg_ready=1, busy=0.
  - phase=0, depth_r=0, rate_r=0, target=INIT_DELAY, state=IDLE.
- Reset mid-glide aborts the glide, same values as above.
- FSM states: IDLE, GLIDE. cfg_ready=1 only in IDLE; busy=1 only in GLIDE.
- Accept occurs when cfg_valid & cfg_ready at a clk edge:
  - depth_r and rate_r latch immediately.
  - target latches max(cfg_delay, 1).
  - If the latched target ≠ base_delay, go to GLIDE; otherwise stay in IDLE.
- GLIDE, on each sample_en:
  - If |target − base_delay| ≤ STEP: base_delay ← target and state ← IDLE.
  - Otherwise base_delay moves STEP toward target.
- An accept in the same cycle as sample_en does not step base_delay that cycle; the first step happens on the next sample_en.
- sample_en outside GLIDE leaves base_delay unchanged.
- cfg_valid held high during GLIDE is ignored; the requester holds it until ready.
- LFO, on each sample_en:
  - tri = phase[15] ? ~phase[14:0] : phase[14:0] (15-bit, 0..32767).
  - bip = tri − 16384 (16-bit signed, −16384..16383).
  - mod_val ← (bip × {0, depth_r}) >>> 14, arithmetic shift with floor, truncated to 16 bits; result range is −depth..depth−1.
  - phase ← phase + rate_r, wrapping mod 2^16.
  - mod_val uses the pre-increment phase.
- rate_r=0 freezes the phase; depth_r=0 gives mod_val=0.
- Latency and alignment:
  - core_en ← sample_en, registered.
  - base_delay and mod_val update on the same edge that registers core_en, so the core sees fresh values in its enabled cycle.
- All arithmetic is sized explicitly; no output glitches since all outputs are registered.

Optional Feature:
- Macro: DELAY_MOD_CTRL_PHASE_RST_EN.
  - Defined: every accepted configuration also clears phase to 0, so the LFO restarts at the −depth extreme on the next sample.
  - Undefined: phase runs continuously across configuration changes; only reset clears it.

Test Plan:
1. Reset, then sample_en pulses with no config:
   - base_delay=1024, mod_val=0, core_en pulses one cycle after each sample_en, cfg_ready=1.
2. Accept cfg_delay=1030, depth=0, rate=0 with STEP=1:
   - busy=1; base_delay goes 1025..1030 over 6 sample_en, then busy=0 and cfg_ready=1.
3. Accept depth=100, rate=0x4000 from phase 0:
   - Successive sample_en give mod_val −100, 0, 99, −1, −100.
4. Accept cfg_delay=0:
   - Target clamps to 1; glide proceeds downward to 1.
   - cfg_valid asserted mid-glide is not accepted until busy=0.
5. Accept coincident with sample_en:
   - No step that cycle.
   - Assert rst_n=0 mid-glide: next cycle base_delay=1024, busy=0, mod_val=0.
6. With DELAY_MOD_CTRL_PHASE_RST_EN, depth=100, rate=0x4000:
   - Re-accept config after 2 samples; next mod_val=−100.
   - Without the macro, the next mod_val is 99.
